// File: rtl/timer_countdown_pkg.sv
// Shared definitions for the microwave countdown timer: FSM encoding, BCD digit layout and limits.
// The optional load-time clamp helper only exists when TIMER_BCD_VALIDATE_EN is defined.
package timer_countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int NUM_DIGITS   = 4;
    localparam int SEC_ONES_LSB = 0;
    localparam int SEC_TENS_LSB = 4;
    localparam int MIN_ONES_LSB = 8;
    localparam int MIN_TENS_LSB = 12;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_FIVE = 4'd5;

    // Only the seconds-tens digit rolls over at 5; every other digit is decimal.
    function automatic logic [3:0] digit_max(input int idx);
        return (idx * 4 == SEC_TENS_LSB) ? BCD_FIVE : BCD_NINE;
    endfunction

`ifdef TIMER_BCD_VALIDATE_EN
    function automatic logic [15:0] clamp_bcd(input logic [15:0] t);
        logic [15:0] r;
        r = t;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (t[i*4 +: 4] > digit_max(i))
                r[i*4 +: 4] = digit_max(i);
        end
        return r;
    endfunction
`endif

endpackage

// File: rtl/timer_countdown_bcd_digit_down.sv
// One BCD digit of the countdown borrow chain.
// When borrowed from, a zero digit reloads with max and passes the borrow upward.
module bcd_digit_down (
    input  logic [3:0] digit,
    input  logic [3:0] max,
    input  logic       borrow_in,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    always_comb begin
        next_digit = digit;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit == 4'd0) begin
                next_digit = max;
                borrow_out = 1'b1;
            end else begin
                next_digit = digit - 4'd1;
            end
        end
    end

endmodule

// File: rtl/timer_countdown.sv
// MM:SS BCD countdown timer for the microwave controller: FSM, 1 Hz prescaler and time register.
// Build option: define TIMER_BCD_VALIDATE_EN to clamp illegal BCD digits on load.
module timer_countdown
    import timer_countdown_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_time,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        done
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    state_t          state_reg, state_next;
    logic [15:0]     time_reg, time_next;
    logic [PW-1:0]   pre_reg, pre_next;
    logic            done_reg, done_next;
    logic            running_reg;
    logic            tick;
    logic [15:0]     dec_time;
    logic [15:0]     load_val;
    logic [NUM_DIGITS:0] borrow;

`ifdef TIMER_BCD_VALIDATE_EN
    assign load_val = clamp_bcd(load_time);
`else
    assign load_val = load_time;
`endif

    assign tick      = (state_reg == ST_RUN) && (pre_reg == TICK_LAST);
    assign borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit_down u_digit (
                .digit      (time_reg[gi*4 +: 4]),
                .max        (digit_max(gi)),
                .borrow_in  (borrow[gi]),
                .next_digit (dec_time[gi*4 +: 4]),
                .borrow_out (borrow[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            time_reg    <= '0;
            pre_reg     <= '0;
            done_reg    <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            time_reg    <= time_next;
            pre_reg     <= pre_next;
            done_reg    <= done_next;
            running_reg <= (state_next == ST_RUN);
        end
    end

    // Prescaler defaults to 0 so any exit from RUN discards the partial second.
    always_comb begin
        state_next = state_reg;
        time_next  = time_reg;
        pre_next   = '0;
        done_next  = 1'b0;
        if (clear) begin
            time_next  = '0;
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (pause) begin
                        state_next = ST_PAUSE;
                    end else if (tick) begin
                        // A borrow out of the top digit cannot occur from a nonzero
                        // time; it is folded into the terminal case regardless.
                        if (dec_time == 16'h0000 || borrow[NUM_DIGITS]) begin
                            time_next  = '0;
                            state_next = ST_DONE;
                            done_next  = 1'b1;
                        end else begin
                            time_next = dec_time;
                        end
                    end else begin
                        pre_next = pre_reg + 1'b1;
                    end
                end
                default: begin
                    if (load) begin
                        time_next  = load_val;
                        state_next = ST_IDLE;
                    end else if (start && state_reg != ST_DONE && time_reg != 16'h0000) begin
                        state_next = ST_RUN;
                    end
                end
            endcase
        end
    end

    assign time_bcd = time_reg;
    assign running  = running_reg;
    assign done     = done_reg;

endmodule
